// File: rtl/vc_deserializer_pkg.sv
// Shared constants and helpers for the narrow-to-wide val/rdy deserializer.
// The word count doubles as the state, so only widths and lane helpers live here.
package vc_deserializer_pkg;

   localparam int unsigned DefaultInNbits = 8;
   localparam int unsigned DefaultNwords  = 4;

   // Phase is decoded from the count register. It is never stored separately.
   typedef enum logic {
      PhaseFill = 1'b0,
      PhaseFull = 1'b1
   } phase_e;

   function automatic int unsigned cntNbits(input int unsigned nwords);
      return $clog2(nwords) + 1;
   endfunction

   function automatic int unsigned laneLsb(input int unsigned lane, input int unsigned nbits);
      return lane * nbits;
   endfunction

endpackage

// File: rtl/vc_deserializer_if.sv
// Generic val/rdy channel. The master drives val/msg and the slave drives rdy.
interface vc_deserializer_if #(
   parameter int unsigned p_nbits = 8
) ();

   logic               val;
   logic               rdy;
   logic [p_nbits-1:0] msg;

   modport master (output val, output msg, input rdy);
   modport slave  (input val, input msg, output rdy);

endinterface

// File: rtl/vc_deserializer_ctrl.sv
// Deserializer control: the word counter, in_rdy/out_val, and the one-hot decode
// that selects which lane captures the incoming narrow word.
module vc_DeserCtrl
   import vc_deserializer_pkg::*;
#(
   parameter  int unsigned p_nwords    = DefaultNwords,
   localparam int unsigned c_cnt_nbits = cntNbits(p_nwords)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_val_i,
   input  logic                   out_rdy_i,
   output logic                   in_rdy_o,
   output logic                   out_val_o,
   output logic [p_nwords-1:0]    lane_en_o,
   output logic [c_cnt_nbits-1:0] count_o
);

   localparam logic [c_cnt_nbits-1:0] FullCount = c_cnt_nbits'(p_nwords);
   localparam logic [c_cnt_nbits-1:0] OneCount  = c_cnt_nbits'(1);

   logic [c_cnt_nbits-1:0] count_q;
   logic [c_cnt_nbits-1:0] count_d;
   phase_e                 phase;
   logic                   doIn;
   logic                   doOut;

   assign phase     = (count_q == FullCount) ? PhaseFull : PhaseFill;
   assign out_val_o = (phase == PhaseFull);

   // When FULL, a word can still enter in the cycle the wide message leaves.
   assign in_rdy_o  = reset && ((phase == PhaseFill) || out_rdy_i);
   assign doIn      = in_val_i && in_rdy_o;
   assign doOut     = out_val_o && out_rdy_i;
   assign count_o   = count_q;

   always_comb begin
      count_d   = count_q;
      lane_en_o = '0;
      if (doIn && doOut) begin
         count_d      = OneCount;
         lane_en_o[0] = 1'b1;
      end else if (doOut) begin
         count_d = '0;
      end else if (doIn) begin
         count_d = count_q + OneCount;
         for (int k = 0; k < int'(p_nwords); k++) begin
            if (count_q == c_cnt_nbits'(k)) begin
               lane_en_o[k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vc_deserializer_enreg.sv
// Enable register with an asynchronous active-low clear. One instance holds one lane.
module vc_EnReg #(
   parameter int unsigned p_nbits = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en_i,
   input  logic [p_nbits-1:0] d_i,
   output logic [p_nbits-1:0] q_o
);

   logic [p_nbits-1:0] data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/vc_deserializer.sv
// Packs p_nwords narrow val/rdy words into one wide message, first word in the LSB lane.
// Pipe-style: a word may enter in the same cycle that a full wide message leaves.
module vc_deserializer
   import vc_deserializer_pkg::*;
#(
   parameter  int unsigned p_in_nbits  = DefaultInNbits,
   parameter  int unsigned p_nwords    = DefaultNwords,
   localparam int unsigned c_cnt_nbits = cntNbits(p_nwords)
) (
   input  logic                   clk,
   input  logic                   reset,
   vc_deserializer_if.slave       in_if,
   vc_deserializer_if.master      out_if,
   output logic [c_cnt_nbits-1:0] count
);

   logic [p_nwords-1:0]            laneEn;
   logic [p_in_nbits*p_nwords-1:0] laneData;
   logic                           inRdy;
   logic                           outVal;

   vc_DeserCtrl #(
      .p_nwords (p_nwords)
   ) u_ctrl (
      .clk       (clk),
      .reset     (reset),
      .in_val_i  (in_if.val),
      .out_rdy_i (out_if.rdy),
      .in_rdy_o  (inRdy),
      .out_val_o (outVal),
      .lane_en_o (laneEn),
      .count_o   (count)
   );

   // Lanes are not cleared on emit. Each one is rewritten before the next out_val.
   for (genvar k = 0; k < int'(p_nwords); k++) begin : g_lane
      vc_EnReg #(
         .p_nbits (p_in_nbits)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .en_i  (laneEn[k]),
         .d_i   (in_if.msg),
         .q_o   (laneData[laneLsb(k, p_in_nbits) +: p_in_nbits])
      );
   end

   assign in_if.rdy  = inRdy;
   assign out_if.val = outVal;
   assign out_if.msg = laneData;

   inValKnown: assert property (@(posedge clk) disable iff (!reset) !$isunknown(in_if.val));

endmodule

// File: tb/tb_vc_deserializer.sv
// Randomized scoreboard bench for vc_deserializer. Accepted words are packed by a
// queue-based model, and a separate monitor compares every emitted wide message.
module tb_vc_deserializer;

   localparam int NB = 8;
   localparam int NW = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] count;

   vc_deserializer_if #(.p_nbits(NB))      inIf ();
   vc_deserializer_if #(.p_nbits(NB * NW)) outIf ();

   vc_deserializer #(
      .p_in_nbits (NB),
      .p_nwords   (NW)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .in_if  (inIf.slave),
      .out_if (outIf.master),
      .count  (count)
   );

   always #5 clk = ~clk;

   int              checkCnt    = 0;
   int              passCnt     = 0;
   int              acceptedCnt = 0;
   int              emittedCnt  = 0;
   int              held;
   int              deqPct      = 50;
   bit              monEn       = 1'b0;
   bit              chainMode   = 1'b0;
   logic [NB-1:0]   partialQ[$];
   logic [NB*NW-1:0] expQ[$];
   logic [NB*NW-1:0] chainExpQ[$];
   logic [NB*NW-1:0] fifoQ[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCnt++;
      if (act === exp) begin
         passCnt++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: collect accepted words and emit one wide word per NW, first word in the low lane.
   task automatic recordWord(input logic [NB-1:0] w);
      logic [NB*NW-1:0] wide;
      partialQ.push_back(w);
      acceptedCnt++;
      if (partialQ.size() == NW) begin
         wide = '0;
         for (int i = 0; i < NW; i++) begin
            wide[i*NB +: NB] = partialQ[i];
         end
         expQ.push_back(wide);
         if (chainMode) chainExpQ.push_back(wide);
         partialQ.delete();
      end
   endtask

   task automatic chainDequeue();
      logic [NB*NW-1:0] got;
      got = fifoQ.pop_front();
      if (chainExpQ.size() == 0) begin
         checkCnt++;
         $display("[TB] FAIL chain_extra: got %0h, expected nothing", got);
      end else begin
         checkOutput("chain_order", 64'(got), 64'(chainExpQ.pop_front()));
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [NB-1:0] w, input logic ordy);
      @(posedge clk);
      #1;
      inIf.val  = v;
      inIf.msg  = w;
      outIf.rdy = chainMode ? (fifoQ.size() < 2) : ordy;
      @(negedge clk);
      if (reset && inIf.val && inIf.rdy) recordWord(w);
      if (chainMode && fifoQ.size() > 0 && $urandom_range(0, 99) < deqPct) chainDequeue();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
   endtask

   // Monitor: samples after the edge, checks control against the model, pops on handshake.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (monEn && reset) begin
            held = acceptedCnt - NW * emittedCnt;
            checkOutput("count", 64'(count), 64'(held));
            checkOutput("out_val", 64'(outIf.val), 64'(held == NW));
            checkOutput("in_rdy", 64'(inIf.rdy), 64'((held < NW) || outIf.rdy));
            if (outIf.val && outIf.rdy) begin
               if (expQ.size() == 0) begin
                  checkCnt++;
                  $display("[TB] FAIL wide_extra: got %0h, expected no message", outIf.msg);
               end else begin
                  checkOutput("wide_msg", 64'(outIf.msg), 64'(expQ.pop_front()));
               end
               emittedCnt++;
               if (chainMode) fifoQ.push_back(outIf.msg);
            end
         end
      end
   end

   initial begin
      reset     = 1'b0;
      inIf.val  = 1'b0;
      inIf.msg  = '0;
      outIf.rdy = 1'b1;
      #12;
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_out_val", 64'(outIf.val), 64'd0);
      checkOutput("reset_in_rdy", 64'(inIf.rdy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      monEn = 1'b1;

      $display("[TB] directed fill of four words");
      applyStimulus(1'b1, 8'h11, 1'b1);
      applyStimulus(1'b1, 8'h22, 1'b1);
      applyStimulus(1'b1, 8'h33, 1'b1);
      applyStimulus(1'b1, 8'h44, 1'b1);
      idle(3);

      $display("[TB] continuous stream of eight words");
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b1);
      idle(3);

      $display("[TB] backpressure while full");
      applyStimulus(1'b1, 8'hAA, 1'b0);
      applyStimulus(1'b1, 8'hBB, 1'b0);
      applyStimulus(1'b1, 8'hCC, 1'b0);
      applyStimulus(1'b1, 8'hDD, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'hEE, 1'b0);
         checkOutput("stall_in_rdy", 64'(inIf.rdy), 64'd0);
         checkOutput("stall_msg", 64'(outIf.msg), 64'hDDCCBBAA);
      end
      applyStimulus(1'b1, 8'hEE, 1'b1);
      applyStimulus(1'b1, 8'hFF, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b1);
      applyStimulus(1'b1, 8'h02, 1'b1);
      idle(3);

      $display("[TB] asynchronous reset mid-message");
      applyStimulus(1'b1, 8'h11, 1'b1);
      applyStimulus(1'b1, 8'h22, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_count", 64'(count), 64'd0);
      checkOutput("async_out_val", 64'(outIf.val), 64'd0);
      checkOutput("async_in_rdy", 64'(inIf.rdy), 64'd0);
      partialQ.delete();
      expQ.delete();
      acceptedCnt = 0;
      emittedCnt  = 0;
      #1;
      reset = 1'b1;
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1);
      idle(3);

      $display("[TB] random valid/ready traffic");
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(1'(($urandom_range(0, 1))), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      idle(10);
      checkOutput("random_drained", 64'(expQ.size()), 64'd0);

      $display("[TB] chain into two-entry queue");
      chainMode = 1'b1;
      deqPct    = 50;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 70), 8'($urandom), 1'b1);
      end
      deqPct = 100;
      idle(12);
      checkOutput("chain_exp_empty", 64'(chainExpQ.size()), 64'd0);
      checkOutput("chain_fifo_empty", 64'(fifoQ.size()), 64'd0);
      checkOutput("chain_wide_empty", 64'(expQ.size()), 64'd0);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/vc_deserializer.md
Name: vc_deserializer

Overview:
Val/rdy deserializer that packs p_nwords consecutive narrow messages into one wide message. Sits directly upstream of a multi-element queue and feeds that queue's enqueue interface, e.g. a byte stream into a word-wide queue. It is a pipe-style stage: when a complete wide message leaves in the same cycle a new narrow word arrives, both transfers happen with no bubble.

Parameters:
p_in_nbits, 8, width of each narrow input message.
p_nwords, 4, narrow words per wide output message; must be at least 2.
c_cnt_nbits, $clog2(p_nwords)+1, derived local constant; width of the word counter; not set externally.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset; state clears immediately while low.
in_val  input  1  narrow input word valid.
in_rdy  output  1  block can accept a narrow word.
in_msg  input  p_in_nbits  narrow input word.
out_val  output  1  wide message complete and valid; drives the queue enq_val.
out_rdy  input  1  downstream can accept; driven by the queue enq_rdy.
out_msg  output  p_in_nbits*p_nwords  wide message; drives the queue enq_msg.
count  output  c_cnt_nbits  number of narrow words currently held, 0..p_nwords.

Behaviour:
- Transfer rules: do_in = in_val && in_rdy; do_out = out_val && out_rdy.
- State is count plus a p_nwords-lane data register; there is no separate FSM register.
  - FILL: count < p_nwords.
  - FULL: count == p_nwords.
- out_val = (count == p_nwords), taken directly from the register. out_msg is the data register output. No combinational path from in_* to out_*.
- in_rdy = reset && ((count < p_nwords) || out_rdy). The combinational out_rdy -> in_rdy path is the pipe behaviour.
- Lane placement: the word accepted when count == k (or k == 0 after an emit) is written to out_msg[k*p_in_nbits +: p_in_nbits]. The first word therefore lands in the LSB lane.
- Next-state rules:
  - do_out && do_in: count <- 1; lane 0 <- in_msg.
  - do_out && !do_in: count <- 0.
  - !do_out && do_in: lane[count] <- in_msg; count <- count+1.
  - Neither: hold.
- Lanes are never cleared on emit. Stale lanes are overwritten before the next out_val, so out_msg is defined only while out_val = 1.
- Latency: a wide message is valid the cycle after its last narrow word is accepted. Sustained throughput is 1 narrow word per cycle when out_rdy stays high.
- Backpressure: in FULL with out_rdy = 0, in_rdy = 0. out_val and out_msg hold stable until the message is accepted.
- Reset (reset == 0, asynchronous): count = 0, all lanes = 0, out_val = 0, in_rdy = 0.
  - Reset mid-message discards the partial words.
  - On the first clk edge after reset deasserts, the block is in FILL with count = 0.
- in_val and out_rdy are sampled only while reset = 1. An in_val that is X outside reset is flagged with the standard not-X assertion.

Decomposition:
- Shared header: lane-index and counter-width localparams only. No state-encoding defines are needed because count encodes the state.
- The lane storage reuses the existing enable-register component, one instance per lane, with the enable derived from a decoded lane select.
- One natural sub-module: vc_DeserCtrl, holding the count register, the in_rdy/out_val logic and the lane-enable decode. The top level wires vc_DeserCtrl to the lane registers.
- Line trace uses the standard val/rdy trace helpers: narrow in, count, wide out.

Test Plan:
1. Reset low, then release, out_rdy = 1; send 0x11, 0x22, 0x33, 0x44 back-to-back -> out_val = 1 exactly one cycle after 0x44 is accepted, out_msg = 0x44332211, count = 4 during that cycle, then count = 0.
2. Continuous stream 0x01..0x08 with out_rdy held at 1 -> in_rdy never drops; 0x04030201 and 0x08070605 are emitted; word 0x05 is accepted in the same cycle 0x04030201 is emitted, and count goes 4 -> 1.
3. Fill to 0xDDCCBBAA with out_rdy = 0 for 5 cycles while in_val = 1 with 0xEE -> in_rdy = 0 and out_msg is stable for all 5 cycles; when out_rdy rises, 0xEE is accepted in the same cycle and lands in lane 0.
4. Send 0x11, 0x22, then pulse reset low mid-cycle -> count, out_val and in_rdy go to 0 immediately (asynchronously); send 0xA1..0xA4 after release -> out_msg = 0xA4A3A2A1 with no stale lanes.
5. Random in_val and out_rdy for 2000 cycles, checked against a reference model that packs words into the same lanes -> every wide message matches, with no drops or duplicates.
6. Drive the full chain vc_deserializer -> 2-entry queue with random deq_rdy -> dequeued wide messages arrive in order and match the packed input stream.
